// File: rtl/u409_flash_pkg.sv
// Shared types and constants for the U409 flash write guard.
// seq_step decodes one JEDEC sequence write against the current state.
package u409_flash_pkg;

  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned BASE_W   = 5;
  localparam int unsigned OFF_W    = 11;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TMR_W    = 16;

  localparam logic [BASE_W-1:0] FLASH_BASE    = 5'h1F;
  localparam logic [TMR_W-1:0]  UNLOCK_WINDOW = 16'd255;
  localparam logic [TMR_W-1:0]  MIN_BUSY      = 16'd8;
  localparam logic [TMR_W-1:0]  RDY_TIMEOUT   = 16'd40000;
  localparam logic [TMR_W-1:0]  TMR_MAX       = 16'hFFFF;

  localparam logic [DATA_W-1:0] CMD_AA = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_55 = 8'h55;
  localparam logic [DATA_W-1:0] CMD_A0 = 8'hA0;
  localparam logic [DATA_W-1:0] CMD_80 = 8'h80;
  localparam logic [DATA_W-1:0] CMD_10 = 8'h10;
  localparam logic [DATA_W-1:0] CMD_30 = 8'h30;
  localparam logic [DATA_W-1:0] CMD_F0 = 8'hF0;

  localparam logic [OFF_W-1:0] OFF_555 = 11'h555;
  localparam logic [OFF_W-1:0] OFF_2AA = 11'h2AA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_U1,
    ST_U2,
    ST_PROG,
    ST_ESET,
    ST_EU1,
    ST_EU2,
    ST_BUSY
  } state_e;

  typedef struct packed {
    logic   ok;
    state_e nxt;
  } step_t;

  // Rejected writes (ok=0) and the F0 reset both land in IDLE.
  function automatic step_t seq_step(state_e cur, logic [DATA_W-1:0] data,
                                     logic [OFF_W-1:0] off);
    step_t s;
    logic  at_555;
    logic  at_2aa;
    at_555 = (off == OFF_555);
    at_2aa = (off == OFF_2AA);
    s      = '{ok: 1'b0, nxt: ST_IDLE};
    if (cur != ST_BUSY && data == CMD_F0) begin
      s.ok = 1'b1;
    end else begin
      case (cur)
        ST_IDLE: if (at_555 && data == CMD_AA) s = '{ok: 1'b1, nxt: ST_U1};
        ST_U1:   if (at_2aa && data == CMD_55) s = '{ok: 1'b1, nxt: ST_U2};
        ST_U2: begin
          if (at_555 && data == CMD_A0)      s = '{ok: 1'b1, nxt: ST_PROG};
          else if (at_555 && data == CMD_80) s = '{ok: 1'b1, nxt: ST_ESET};
        end
        ST_PROG: s = '{ok: 1'b1, nxt: ST_BUSY};
        ST_ESET: if (at_555 && data == CMD_AA) s = '{ok: 1'b1, nxt: ST_EU1};
        ST_EU1:  if (at_2aa && data == CMD_55) s = '{ok: 1'b1, nxt: ST_EU2};
        ST_EU2: begin
          if ((at_555 && data == CMD_10) || data == CMD_30) s = '{ok: 1'b1, nxt: ST_BUSY};
        end
        default: s = '{ok: 1'b0, nxt: ST_IDLE};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/u409_flash_timer.sv
// Saturating 16-bit cycle counter shared by the unlock window and the busy period.
module u409_flash_timer
  import u409_flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ge_min_c,
  output logic ge_win_c,
  output logic ge_tmo_c
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != TMR_MAX) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign ge_min_c = (cnt >= MIN_BUSY);
  assign ge_win_c = (cnt >= UNLOCK_WINDOW);
  assign ge_tmo_c = (cnt >= RDY_TIMEOUT);

endmodule

// File: rtl/u409_flash_guard.sv
// Flash window decode and JEDEC command-sequence write gate in front of the
// U409 flash cycle machine; tracks the embedded-algorithm busy period.
module u409_flash_guard
  import u409_flash_pkg::*;
(
  input  logic                CLK40,
  input  logic                RESET,
  input  logic                TSn,
  input  logic                RnW,
  input  logic [ADDR_MSB:1]   A,
  input  logic [DATA_W-1:0]   D_LO,
  input  logic                PROG_EN,
  input  logic                FLASH_RDY,
  input  logic                CLR_TIMEOUT,
  output logic                FLASH_SPACE,
  output logic                FLASH_TEAn,
  output logic                FLASH_BUSY,
  output logic                FLASH_TIMEOUT
);

  state_e state;
  state_e state_nxt;
  step_t  step;
  logic   hit;
  logic   wr_evt;
  logic   permit;
  logic   accept;
  logic   tmr_en;
  logic   tea_nxt;
  logic   tmo_set;
  logic   ge_min;
  logic   ge_win;
  logic   ge_tmo;
  logic   unused_addr;

  assign hit         = (A[ADDR_MSB:ADDR_MSB-BASE_W+1] == FLASH_BASE);
  assign wr_evt      = !TSn && hit && !RnW;
  assign step        = seq_step(state, D_LO, A[OFF_W:1]);
  assign permit      = PROG_EN && step.ok;
  assign accept      = wr_evt && permit;
  assign tmr_en      = (state != ST_IDLE);
  assign unused_addr = ^A[ADDR_MSB-BASE_W:OFF_W+1];

  // Combinational so the downstream cycle machine samples it on the TSn edge.
  assign FLASH_SPACE = !RESET && hit && (RnW || permit);

  u409_flash_timer u_timer (
    .clk      (CLK40),
    .rst      (RESET),
    .clr      (accept),
    .en       (tmr_en),
    .ge_min_c (ge_min),
    .ge_win_c (ge_win),
    .ge_tmo_c (ge_tmo)
  );

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      FLASH_TEAn    <= 1'b1;
      FLASH_BUSY    <= 1'b0;
      FLASH_TIMEOUT <= 1'b0;
    end else begin
      state         <= state_nxt;
      FLASH_TEAn    <= !tea_nxt;
      FLASH_BUSY    <= (state_nxt == ST_BUSY);
      FLASH_TIMEOUT <= tmo_set || (FLASH_TIMEOUT && !CLR_TIMEOUT);
    end
  end

  // BUSY ignores PROG_EN and writes; a ready flash wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    tea_nxt   = 1'b0;
    tmo_set   = 1'b0;
    if (wr_evt && !permit) begin
      tea_nxt = 1'b1;
    end
    if (state == ST_BUSY) begin
      if (ge_min && FLASH_RDY) begin
        state_nxt = ST_IDLE;
      end else if (ge_tmo) begin
        tmo_set   = 1'b1;
        state_nxt = ST_IDLE;
      end
    end else if (!PROG_EN) begin
      state_nxt = ST_IDLE;
    end else if (wr_evt) begin
      state_nxt = step.nxt;
    end else if (state != ST_IDLE && ge_win) begin
      state_nxt = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_u409_flash_guard.sv
// Randomized + directed bench for u409_flash_guard: a command-history reference
// model queues expected responses, a monitor compares them against the DUT.
module tb_u409_flash_guard;

  logic        CLK40 = 1'b0;
  logic        RESET = 1'b0;
  logic        TSn = 1'b1;
  logic        RnW = 1'b1;
  logic [23:1] A = '0;
  logic [7:0]  D_LO = '0;
  logic        PROG_EN = 1'b1;
  logic        FLASH_RDY = 1'b1;
  logic        CLR_TIMEOUT = 1'b0;
  logic        FLASH_SPACE;
  logic        FLASH_TEAn;
  logic        FLASH_BUSY;
  logic        FLASH_TIMEOUT;

  int n_cmp = 0;
  int n_bad = 0;

  logic nx_rdy = 1'b1;
  logic nx_prog = 1'b1;
  logic nx_clr = 1'b0;

  typedef struct packed {
    logic xfer;
    logic space;
    logic tean;
    logic busy;
    logic tmo;
  } exp_t;
  exp_t sb[$];

  // Reference model: accepted sequence writes so far plus busy/timeout bookkeeping.
  logic [7:0]  h_d[$];
  logic [10:0] h_o[$];
  bit m_busy = 0;
  bit m_tmo = 0;
  int m_bcnt = 0;
  int m_idle = 0;

  u409_flash_guard dut (
    .CLK40        (CLK40),
    .RESET        (RESET),
    .TSn          (TSn),
    .RnW          (RnW),
    .A            (A),
    .D_LO         (D_LO),
    .PROG_EN      (PROG_EN),
    .FLASH_RDY    (FLASH_RDY),
    .CLR_TIMEOUT  (CLR_TIMEOUT),
    .FLASH_SPACE  (FLASH_SPACE),
    .FLASH_TEAn   (FLASH_TEAn),
    .FLASH_BUSY   (FLASH_BUSY),
    .FLASH_TIMEOUT(FLASH_TIMEOUT)
  );

  always #5 CLK40 = ~CLK40;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b, required %b", name, $time, act, req);
    end
  endtask

  // Element i of the program (erase=0) or chip/sector erase (erase=1) sequence.
  function automatic bit el_ok(bit erase, int i, logic [7:0] d, logic [10:0] o);
    if (!erase) begin
      case (i)
        0: return d == 8'hAA && o == 11'h555;
        1: return d == 8'h55 && o == 11'h2AA;
        2: return d == 8'hA0 && o == 11'h555;
        3: return 1'b1;
        default: return 1'b0;
      endcase
    end else begin
      case (i)
        0: return d == 8'hAA && o == 11'h555;
        1: return d == 8'h55 && o == 11'h2AA;
        2: return d == 8'h80 && o == 11'h555;
        3: return d == 8'hAA && o == 11'h555;
        4: return d == 8'h55 && o == 11'h2AA;
        5: return (d == 8'h10 && o == 11'h555) || d == 8'h30;
        default: return 1'b0;
      endcase
    end
  endfunction

  function automatic bit seq_match(bit erase, logic [7:0] d, logic [10:0] o);
    for (int i = 0; i < h_d.size(); i++)
      if (!el_ok(erase, i, h_d[i], h_o[i])) return 1'b0;
    return el_ok(erase, h_d.size(), d, o);
  endfunction

  task automatic m_clear();
    h_d.delete();
    h_o.delete();
    m_idle = 0;
  endtask

  task automatic cycle(input logic tsn, input logic rnw, input logic [23:1] a, input logic [7:0] d);
    logic hit, wr, pm, pp, pe, fin, tset;
    exp_t e;
    @(negedge CLK40);
    TSn = tsn; RnW = rnw; A = a; D_LO = d;
    PROG_EN = nx_prog; FLASH_RDY = nx_rdy; CLR_TIMEOUT = nx_clr;
    hit  = (a[23:19] == 5'h1F);
    wr   = !tsn && hit && !rnw;
    pp   = seq_match(1'b0, d, a[11:1]);
    pe   = seq_match(1'b1, d, a[11:1]);
    pm   = PROG_EN && !m_busy && (d == 8'hF0 || pp || pe);
    fin  = pm && d != 8'hF0 && ((pp && h_d.size() == 3) || (pe && h_d.size() == 5));
    tset = 1'b0;
    e.xfer  = !tsn;
    e.space = hit && (rnw || pm);
    e.tean  = !(wr && !pm);
    if (m_busy) begin
      if (m_bcnt >= 8 && FLASH_RDY) m_busy = 0;
      else if (m_bcnt >= 40000) begin m_busy = 0; tset = 1'b1; end
      else if (m_bcnt < 65535) m_bcnt++;
    end else if (!PROG_EN) begin
      m_clear();
    end else if (wr) begin
      if (!pm || d == 8'hF0) m_clear();
      else if (fin) begin m_clear(); m_busy = 1; m_bcnt = 0; end
      else begin h_d.push_back(d); h_o.push_back(a[11:1]); m_idle = 0; end
    end else if (h_d.size() > 0) begin
      if (m_idle >= 255) m_clear();
      else m_idle++;
    end
    m_tmo  = tset || (m_tmo && !CLR_TIMEOUT);
    e.busy = m_busy;
    e.tmo  = m_tmo;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [10:0] o, input logic [7:0] d);
    cycle(1'b0, 1'b0, {5'h1F, 7'h00, o}, d);
  endtask

  task automatic rd(input logic [10:0] o);
    cycle(1'b0, 1'b1, {5'h1F, 7'h00, o}, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 23'h0, 8'h00);
  endtask

  task automatic reset_pulse();
    @(posedge CLK40); #3;
    check("pre_rst_busy", {2'b00, FLASH_BUSY}, 3'b001);
    RESET = 1'b1; RnW = 1'b1; TSn = 1'b0; A = {5'h1F, 18'h00100};
    #1;
    check("rst_busy", {2'b00, FLASH_BUSY}, 3'b000);
    check("rst_space", {2'b00, FLASH_SPACE}, 3'b000);
    check("rst_tea", {2'b00, FLASH_TEAn}, 3'b001);
    m_clear(); m_busy = 0; m_bcnt = 0; m_tmo = 0;
    @(negedge CLK40);
    RESET = 1'b0; TSn = 1'b1;
  endtask

  task automatic script_elem(input bit er, input int pos, output logic [7:0] d, output logic [10:0] o);
    d = 8'($urandom); o = 11'($urandom);
    case (pos)
      0, 3: if (!er || pos == 3) begin d = (er || pos == 0) ? 8'hAA : d; o = (er || pos == 0) ? 11'h555 : o; end
      1, 4: begin d = 8'h55; o = 11'h2AA; end
      2:    begin d = er ? 8'h80 : 8'hA0; o = 11'h555; end
      5:    if ($urandom_range(0, 1) == 0) begin d = 8'h10; o = 11'h555; end else d = 8'h30;
      default: ;
    endcase
  endtask

  // Monitor: compares FLASH_SPACE on each presented transfer, status every clock.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK40); #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.xfer) check("space", {2'b00, FLASH_SPACE}, {2'b00, e.space});
        @(posedge CLK40); #1;
        check("tea_busy_tmo", {FLASH_TEAn, FLASH_BUSY, FLASH_TIMEOUT}, {e.tean, e.busy, e.tmo});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit er;
    int pos;
    logic [7:0] d;
    logic [10:0] o;
    #1 RESET = 1'b1;
    TSn = 1'b0; RnW = 1'b1; A = {5'h1F, 18'h00100};
    #2;
    check("reset_space", {2'b00, FLASH_SPACE}, 3'b000);
    check("reset_status", {FLASH_TEAn, FLASH_BUSY, FLASH_TIMEOUT}, 3'b100);
    @(negedge CLK40);
    RESET = 1'b0; TSn = 1'b1;

    // Program with the flash busy for 20 clocks; read and blocked write mid-busy.
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); wr(11'h555, 8'hA0);
    nx_rdy = 1'b0;
    wr(11'h100, 8'h34);
    idle(5); rd(11'h100); idle(3); wr(11'h100, 8'h55); idle(9);
    nx_rdy = 1'b1;
    idle(4);

    // Stray write in IDLE.
    wr(11'h010, 8'h00); idle(3);

    // Chip erase that never sees ready, then clear the timeout flag.
    nx_rdy = 1'b0;
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); wr(11'h555, 8'h80);
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); wr(11'h555, 8'h10);
    idle(40010);
    nx_rdy = 1'b1;
    idle(2); nx_clr = 1'b1; idle(1); nx_clr = 1'b0; idle(2);

    // Unlock window expiry, then exact-boundary gaps.
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); idle(300); wr(11'h555, 8'hA0); idle(2);
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); idle(255); wr(11'h555, 8'hA0); wr(11'h200, 8'h77); idle(12);
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); idle(256); wr(11'h555, 8'hA0); idle(2);

    // PROG_EN dropped in U2; F0 in PROG returns to IDLE.
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55);
    nx_prog = 1'b0; idle(1); nx_prog = 1'b1;
    wr(11'h555, 8'hA0); idle(2);
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); wr(11'h555, 8'hA0); wr(11'h300, 8'hF0); idle(2);

    // Reset mid-busy.
    nx_rdy = 1'b0;
    wr(11'h555, 8'hAA); wr(11'h2AA, 8'h55); wr(11'h555, 8'hA0); wr(11'h100, 8'h12);
    idle(3);
    reset_pulse();
    nx_rdy = 1'b1;
    idle(2);

    // Random traffic against the model.
    er = 1'b0; pos = 0;
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      nx_rdy  = ($urandom_range(0, 9) < 7);
      nx_clr  = ($urandom_range(0, 19) == 0);
      nx_prog = ($urandom_range(0, 29) != 0);
      if (r < 55) begin
        script_elem(er, pos, d, o);
        wr(o, d);
        pos++;
        if (pos == (er ? 6 : 4)) begin pos = 0; er = 1'($urandom_range(0, 1)); end
      end else if (r < 65) wr(11'($urandom), 8'($urandom));
      else if (r < 70) wr(11'($urandom), 8'hF0);
      else if (r < 80) rd(11'($urandom));
      else if (r < 85) cycle(1'b0, 1'($urandom_range(0, 1)), {5'($urandom_range(0, 30)), 18'($urandom)}, 8'($urandom));
      else if (r < 99) idle($urandom_range(1, 4));
      else idle($urandom_range(253, 257));
    end
    nx_prog = 1'b1; nx_clr = 1'b0; nx_rdy = 1'b1;
    idle(3);
    repeat (4) @(negedge CLK40);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/u409_flash_guard.md
# u409_flash_guard

Write-gating front end for the U409 flash cycle machine: decodes the flash window from the CPU address, lets reads through unconditionally and passes writes only when they form a valid JEDEC command sequence (program or sector/chip erase) while programming is enabled. Drives FLASH_SPACE into the flash cycle state machine directly downstream, terminates illegal writes with a one-clock transfer error, and tracks the embedded-algorithm busy period with a timeout.

## Interface
- FLASH_BASE, 5'h1F: value of A[23:19] that selects the flash window ($F80000–$FFFFFF).
- UNLOCK_WINDOW, 8'd255: idle clocks allowed between sequence writes before the sequence is abandoned.
- MIN_BUSY, 4'd8: clocks after the committing write before FLASH_RDY is trusted.
- RDY_TIMEOUT, 16'd40000: clocks (1 ms at 40 MHz) allowed in BUSY.
- CLK40  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TSn  in  1  CPU transfer start, active low.
- RnW  in  1  1 = read, 0 = write.
- A  in  23  A[23:1] word address.
- D_LO  in  8  write data D[7:0].
- PROG_EN  in  1  system programming enable.
- FLASH_RDY  in  1  flash ready/busy pin, 1 = ready.
- CLR_TIMEOUT  in  1  one-clock pulse clearing FLASH_TIMEOUT.
- FLASH_SPACE  out  1  combinational; qualifies this transfer for the flash cycle machine.
- FLASH_TEAn  out  1  transfer error for blocked writes, active low.
- FLASH_BUSY  out  1  high while in BUSY.
- FLASH_TIMEOUT  out  1  sticky timeout flag.

## Operation
- Reset values: state IDLE, FLASH_TEAn=1, FLASH_BUSY=0, FLASH_TIMEOUT=0, counters 0; FLASH_SPACE=0 while RESET high.
- HIT = (A[23:19]==FLASH_BASE). Read: FLASH_SPACE = HIT in every state. Write: FLASH_SPACE = HIT && PERMIT, where PERMIT is evaluated from the current (pre-edge) state.
- A write event is a rising edge with TSn=0, HIT, RnW=0. Off = A[11:1].
- States and permitted writes (other writes block):
  - IDLE: AA@555 -> U1.
  - U1: 55@2AA -> U2.
  - U2: A0@555 -> PROG; 80@555 -> ESET.
  - PROG: any address/data -> BUSY.
  - ESET: AA@555 -> EU1.
  - EU1: 55@2AA -> EU2.
  - EU2: 10@555 or 30@any -> BUSY.
  - BUSY: no writes permitted.
- F0 written anywhere in a non-BUSY state is always permitted and returns the state to IDLE.
- Blocked write: FLASH_SPACE=0 for that transfer; FLASH_TEAn low for exactly the next clock; state -> IDLE, except in BUSY, where the state is held.
- PROG_EN=0: all writes block; non-BUSY states are forced to IDLE. A BUSY period in progress runs to completion.
- Reads never change state and never restart the window counter.
- Window: in U1/U2/PROG/ESET/EU1/EU2 a counter restarts on each accepted write; reaching UNLOCK_WINDOW -> IDLE, no error.
- BUSY: a 16-bit counter starts at 0 on entry. Exit to IDLE when count >= MIN_BUSY and FLASH_RDY=1. If the count reaches RDY_TIMEOUT first: set FLASH_TIMEOUT and go to IDLE. The counter saturates and never wraps.
- FLASH_TIMEOUT clears on CLR_TIMEOUT. A simultaneous set and clear leaves it set.

## Timing
- FLASH_SPACE is valid in the same clock as TSn low, so the downstream machine samples it at that edge.
- State update, window restart and TEA scheduling occur at the write-event edge. FLASH_TEAn falls one clock later and lasts one clock.
- FLASH_BUSY rises on the edge after the committing write and falls on the exit edge.
- Minimum BUSY length: MIN_BUSY+1 clocks.
- RESET asserted mid-sequence or mid-BUSY returns all outputs to their reset values immediately (asynchronous).

## Structure
- Package u409_flash_pkg: state enumeration (3-bit); command constants AA, 55, A0, 80, 10, 30, F0; offsets 11'h555 and 11'h2AA.
- Sub-module u409_flash_timer: 16-bit saturating counter with clear/enable and compare outputs. One instance serves both the window and the busy timing, since they are never active together.

## Test plan
- Program: write AA@555, 55@2AA, A0@555, 1234@00100; FLASH_RDY low for 20 clocks then high -> FLASH_SPACE=1 on all four writes, FLASH_BUSY high for 20 clocks, FLASH_TEAn never low.
- Stray write 00@00010 in IDLE -> FLASH_SPACE=0, FLASH_TEAn low for exactly one clock, state stays IDLE.
- Read during BUSY at 00100 -> FLASH_SPACE=1. Write during BUSY -> blocked, TEA pulse, BUSY continues.
- Chip erase: AA/55/80/AA/55/10 with FLASH_RDY held low -> BUSY for RDY_TIMEOUT clocks, then FLASH_TIMEOUT=1 and state IDLE; CLR_TIMEOUT -> FLASH_TIMEOUT=0.
- AA@555, 55@2AA, then 300 idle clocks, then A0@555 -> window expires at 255 clocks, A0 is blocked with a TEA pulse.
- PROG_EN dropped while in U2 -> IDLE. RESET pulsed mid-BUSY -> FLASH_BUSY=0 immediately.
